sobel_mem_ctrl: RTL and testbench
=================================

# sobel_mem_ctrl

Window-fetch and write-back sequencer for the Sobel edge-detection datapath. It sits directly upstream of the AHB master and drives its byte command interface (instruction / addr_r / addr_w / data_w, with busy / data_r returned). For every interior pixel of a source image, it reads the 3x3 neighbourhood byte by byte. It hands the window to the Sobel compute core over a valid/ready handshake, collects the 8-bit result and writes it to the destination image.

## Interface
- IMG_W, 8, image width in pixels (≥3)
- IMG_H, 8, image height in pixels (≥3)
- SRC_BASE, 8'd0, byte address of source pixel (0,0)
- DST_BASE, 8'd64, byte address of destination pixel (1,1)

- HCLK  in  1  clock, rising edge
- HRESET  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when IDLE
- done  out  1  one-cycle pulse after last write completes
- instruction  out  2  to master: 00 idle, 01 read, 10 write
- addr_r  out  8  read byte address
- addr_w  out  8  write byte address
- data_w  out  8  write byte
- data_r  in  8  read byte from master
- busy  in  1  master stall; command/data not accepted while high
- win_valid  out  1  window available
- win_ready  in  1  Sobel core accepts window
- win_data  out  72  row-major window, p0 (top-left) at [7:0], p8 (bottom-right) at [71:64]
- res_ready  out  1  sequencer waiting for result
- res_valid  in  1  result strobe
- res_data  in  8  edge magnitude

## Operation
- Counters: row r in 1..IMG_H-2, col c in 1..IMG_W-2, tap k in 0..8. Tap k reads pixel (r-1+k/3, c-1+k%3).
- Read address = SRC_BASE + row*IMG_W + col. Write address = DST_BASE + (r-1)*(IMG_W-2) + (c-1). Both are truncated to 8 bits and wrap modulo 256.
- States:
  - IDLE: start → RD_REQ, with r=1, c=1, k=0.
  - RD_REQ: instruction=01, addr_r valid. busy=0 → RD_WAIT.
  - RD_WAIT: instruction=00. busy=0 → capture data_r into tap k. If k=8 → WIN_OUT, else k++ and → RD_REQ.
  - WIN_OUT: win_valid=1. win_ready=1 → RES_WAIT.
  - RES_WAIT: res_ready=1. res_valid=1 → latch res_data, → WR_REQ.
  - WR_REQ: instruction=10, addr_w and data_w valid. busy=0 → WR_WAIT.
  - WR_WAIT: instruction=00. busy=0 → advance c, wrapping to 1 and incrementing r at the row end, k=0. After the last pixel → DONE, else → RD_REQ.
  - DONE: done=1 for one cycle → IDLE.
- start is ignored outside IDLE.
- While busy=1: instruction, addr_r, addr_w and data_w are held constant.
- win_data is stable from WIN_OUT entry until the next RD_WAIT capture. res_data is ignored outside RES_WAIT.
- Outputs are registered; no output depends combinationally on busy, win_ready or res_valid.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, including instruction=00, win_data=0, done=0. Counters r=1, c=1, k=0.
- HRESET asserted mid-frame aborts immediately; no done is issued and no further commands are sent.
- Minimum cycles per output pixel with busy=0 and zero-latency handshakes: 18 (reads) + 1 (window) + 1 (result) + 2 (write) = 22.
- First RD_REQ is one cycle after start is sampled. done asserts the cycle after the final WR_WAIT completion.
- Default 8x8 frame: 36 output pixels, 792 cycles minimum from RD_REQ entry to DONE.
- Each busy=1 cycle adds exactly one cycle in the current REQ/WAIT state.
- win_ready/res_valid high on entry cycle → transition occurs at that same edge.

## Test plan
- **Basic frame.** Defaults, busy=0, memory byte = its address, core echoes p4. Required response:
  - First window win_data bytes {0,1,2,8,9,10,16,17,18}.
  - First write addr_w=64, data_w=9.
  - Last write addr_w=99, data_w=54.
  - Exactly 36 writes, done pulse once.
- **Master stall.** Hold busy=1 for 3 cycles on the first RD_REQ and on a WR_REQ. instruction/addr/data stay constant throughout; the pixel takes 25 cycles; results match the basic frame.
- **Core backpressure.** win_ready low 5 cycles, res_valid delayed 4 cycles. win_valid and win_data stay stable; no command is issued meanwhile; res_data is captured only in RES_WAIT.
- **Start ignored.** Pulse start again mid-frame. No restart; counters unaffected; a single done.
- **Reset mid-op.** Assert HRESET during RD_WAIT of pixel 10. All outputs go to 0 immediately and the block sits in IDLE. A new start restarts from addr_r=0.
- **Minimum image with wrap.** IMG_W=IMG_H=3, SRC_BASE=8'd250, DST_BASE=8'd255. Reads wrap: addresses 250,251,252,253,254,255,0,1,2. One write at addr_w=255, then done.

Source files
------------

// File: rtl/sobel_mem_ctrl.sv
// Sobel window-fetch / write-back sequencer.
// Reads each interior pixel's 3x3 neighbourhood byte by byte through the AHB master's
// byte command port. It then hands the window to the Sobel core and writes the core's
// result to the destination image.
module sobel_mem_ctrl #(
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8,
  parameter logic [7:0]  SRC_BASE = 8'd0,
  parameter logic [7:0]  DST_BASE = 8'd64
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  output logic        done,
  output logic [1:0]  instruction,
  output logic [7:0]  addr_r,
  output logic [7:0]  addr_w,
  output logic [7:0]  data_w,
  input  logic [7:0]  data_r,
  input  logic        busy,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] win_data,
  output logic        res_ready,
  input  logic        res_valid,
  input  logic [7:0]  res_data
);

  localparam logic [1:0] InstIdle  = 2'b00;
  localparam logic [1:0] InstRead  = 2'b01;
  localparam logic [1:0] InstWrite = 2'b10;

  localparam logic [7:0] LastRow = 8'(IMG_H - 2);
  localparam logic [7:0] LastCol = 8'(IMG_W - 2);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWinOut,
    StResWait,
    StWrReq,
    StWrWait,
    StDone
  } state_e;

  state_e     state_q;
  logic [7:0] row_q;
  logic [7:0] col_q;
  logic [3:0] tap_q;

  logic [7:0] next_row;
  logic [7:0] next_col;
  logic       last_pix;

  // Source byte address of tap k of the window centred on (r, c); wraps modulo 256.
  function automatic logic [7:0] rd_addr(input logic [7:0] r, input logic [7:0] c,
                                         input logic [3:0] k);
    return 8'(32'(SRC_BASE) + (32'(r) + 32'(k / 4'd3) - 32'd1) * IMG_W
              + 32'(c) + 32'(k % 4'd3) - 32'd1);
  endfunction

  // Destination byte address of the output for centre (r, c); wraps modulo 256.
  function automatic logic [7:0] wr_addr(input logic [7:0] r, input logic [7:0] c);
    return 8'(32'(DST_BASE) + (32'(r) - 32'd1) * (IMG_W - 2) + 32'(c) - 32'd1);
  endfunction

  // Raster advance to the next interior pixel.
  always_comb begin
    next_row = row_q;
    next_col = col_q + 8'd1;
    if (col_q == LastCol) begin
      next_row = row_q + 8'd1;
      next_col = 8'd1;
    end
    last_pix = (row_q == LastRow) && (col_q == LastCol);
  end

  // Sequencer FSM; every output is loaded on the edge that enters the state using it,
  // so nothing reaches an output combinationally from busy/win_ready/res_valid.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q     <= StIdle;
      row_q       <= 8'd1;
      col_q       <= 8'd1;
      tap_q       <= 4'd0;
      done        <= 1'b0;
      instruction <= InstIdle;
      addr_r      <= 8'd0;
      addr_w      <= 8'd0;
      data_w      <= 8'd0;
      win_valid   <= 1'b0;
      win_data    <= 72'd0;
      res_ready   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StRdReq;
            row_q       <= 8'd1;
            col_q       <= 8'd1;
            tap_q       <= 4'd0;
            instruction <= InstRead;
            addr_r      <= rd_addr(8'd1, 8'd1, 4'd0);
          end
        end
        StRdReq: begin
          if (!busy) begin
            state_q     <= StRdWait;
            instruction <= InstIdle;
          end
        end
        StRdWait: begin
          if (!busy) begin
            for (int i = 0; i < 9; i++) begin
              if (tap_q == 4'(i)) win_data[i*8 +: 8] <= data_r;
            end
            if (tap_q == 4'd8) begin
              state_q   <= StWinOut;
              win_valid <= 1'b1;
            end else begin
              state_q     <= StRdReq;
              tap_q       <= tap_q + 4'd1;
              instruction <= InstRead;
              addr_r      <= rd_addr(row_q, col_q, tap_q + 4'd1);
            end
          end
        end
        StWinOut: begin
          if (win_ready) begin
            state_q   <= StResWait;
            win_valid <= 1'b0;
            res_ready <= 1'b1;
          end
        end
        StResWait: begin
          if (res_valid) begin
            state_q     <= StWrReq;
            res_ready   <= 1'b0;
            data_w      <= res_data;
            addr_w      <= wr_addr(row_q, col_q);
            instruction <= InstWrite;
          end
        end
        StWrReq: begin
          if (!busy) begin
            state_q     <= StWrWait;
            instruction <= InstIdle;
          end
        end
        StWrWait: begin
          if (!busy) begin
            tap_q <= 4'd0;
            if (last_pix) begin
              state_q <= StDone;
              row_q   <= 8'd1;
              col_q   <= 8'd1;
              done    <= 1'b1;
            end else begin
              state_q     <= StRdReq;
              row_q       <= next_row;
              col_q       <= next_col;
              instruction <= InstRead;
              addr_r      <= rd_addr(next_row, next_col, 4'd0);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_mem_ctrl.sv
// Directed bench for sobel_mem_ctrl: an 8x8 instance (memory byte = address, core echoes
// the window centre) and a 3x3 instance whose source and destination addresses wrap.
module tb_sobel_mem_ctrl;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  // 8x8 instance
  logic        start, done, busy, win_valid, win_ready, res_ready, res_valid;
  logic [1:0]  instruction;
  logic [7:0]  addr_r, addr_w, data_w, data_r, res_data;
  logic [71:0] win_data;
  logic        use_force;
  logic [7:0]  res_force;

  assign data_r   = addr_r;
  assign res_data = use_force ? res_force : win_data[39:32];

  sobel_mem_ctrl u_dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .start       (start),
    .done        (done),
    .instruction (instruction),
    .addr_r      (addr_r),
    .addr_w      (addr_w),
    .data_w      (data_w),
    .data_r      (data_r),
    .busy        (busy),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_data    (win_data),
    .res_ready   (res_ready),
    .res_valid   (res_valid),
    .res_data    (res_data)
  );

  // 3x3 wrapping instance
  logic        start2, done2, win_valid2, res_ready2;
  logic [1:0]  inst2;
  logic [7:0]  addr_r2, addr_w2, data_w2;
  logic [71:0] win_data2;

  sobel_mem_ctrl #(
    .IMG_W    (3),
    .IMG_H    (3),
    .SRC_BASE (8'd250),
    .DST_BASE (8'd255)
  ) u_min (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .start       (start2),
    .done        (done2),
    .instruction (inst2),
    .addr_r      (addr_r2),
    .addr_w      (addr_w2),
    .data_w      (data_w2),
    .data_r      (addr_r2),
    .busy        (1'b0),
    .win_valid   (win_valid2),
    .win_ready   (1'b1),
    .win_data    (win_data2),
    .res_ready   (res_ready2),
    .res_valid   (1'b1),
    .res_data    (win_data2[39:32])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Write monitor for the 8x8 instance: a write is accepted when instruction leaves 10.
  int          wr_cnt = 0, wr_bad = 0, fidx = 0, done_cnt = 0, win_cnt = 0;
  logic [1:0]  prev_inst = 2'b00;
  logic        prev_wv = 1'b0;
  logic [7:0]  first_wa, first_wd, last_wa, last_wd;
  logic [71:0] first_win;

  always @(negedge HCLK) begin
    #1;
    if (!HRESET) begin
      fidx = 0;
    end else begin
      if (prev_inst == 2'b10 && instruction != 2'b10) begin
        if (wr_cnt == 0) begin
          first_wa = addr_w;
          first_wd = data_w;
        end
        if (addr_w !== 8'(64 + fidx) || data_w !== 8'((1 + fidx / 6) * 8 + 1 + fidx % 6))
          wr_bad++;
        last_wa = addr_w;
        last_wd = data_w;
        wr_cnt++;
        fidx++;
      end
      if (win_valid && !prev_wv) begin
        if (win_cnt == 0) first_win = win_data;
        win_cnt++;
      end
      if (done) begin
        done_cnt++;
        fidx = 0;
      end
    end
    prev_inst = instruction;
    prev_wv   = win_valid;
  end

  // Monitor for the 3x3 instance: read addresses in issue order, writes, done pulses.
  int          rd2_cnt = 0, wr2_cnt = 0, done2_cnt = 0;
  logic [71:0] rd2_pack = 72'd0;
  logic [1:0]  prev_inst2 = 2'b00;
  logic [7:0]  wr2_a, wr2_d;

  always @(negedge HCLK) begin
    #1;
    if (HRESET) begin
      if (prev_inst2 == 2'b01 && inst2 != 2'b01) begin
        rd2_pack = {addr_r2, rd2_pack[71:8]};
        rd2_cnt++;
      end
      if (prev_inst2 == 2'b10 && inst2 != 2'b10) begin
        wr2_a = addr_w2;
        wr2_d = data_w2;
        wr2_cnt++;
      end
      if (done2) done2_cnt++;
    end
    prev_inst2 = inst2;
  end

  task automatic go();
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 4000) begin
      @(negedge HCLK);
      c++;
    end
    #2;
  endtask

  int          cyc, n, base_wr, base_done, base_bad;
  logic        ok;
  logic [71:0] w;

  initial begin
    HRESET    = 1'b0;
    start     = 1'b0;
    start2    = 1'b0;
    busy      = 1'b0;
    win_ready = 1'b1;
    res_valid = 1'b1;
    use_force = 1'b0;
    res_force = 8'h00;

    // Reset state
    repeat (2) @(negedge HCLK);
    chk("rst_inst", instruction, 2'b00);
    chk("rst_addrs", {addr_r, addr_w, data_w}, 24'd0);
    chk("rst_flags", {done, win_valid, res_ready}, 3'b000);
    chk("rst_win", win_data, 72'd0);
    HRESET = 1'b1;

    // Basic frame
    base_wr = wr_cnt; base_done = done_cnt; base_bad = wr_bad;
    go();
    chk("first_rd_inst", instruction, 2'b01);
    chk("first_rd_addr", addr_r, 8'd0);
    wait_done(cyc);
    chk("frame_cycles", cyc, 792);
    chk("first_window", first_win, 72'h12_11_10_0A_09_08_02_01_00);
    chk("first_write", {first_wa, first_wd}, {8'd64, 8'd9});
    chk("last_write", {last_wa, last_wd}, {8'd99, 8'd54});
    chk("write_count", wr_cnt - base_wr, 36);
    chk("write_seq", wr_bad - base_bad, 0);
    chk("done_count", done_cnt - base_done, 1);
    @(negedge HCLK);
    chk("done_pulse", {done, instruction}, 3'b000);

    // Master stall on the first read and on pixel 1's write
    base_wr = wr_cnt; base_done = done_cnt; base_bad = wr_bad;
    go();
    busy = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      if (instruction !== 2'b01 || addr_r !== 8'd0) ok = 1'b0;
    end
    busy = 1'b0;
    chk("rd_stall_hold", ok, 1'b1);
    cyc = 3;
    while (instruction != 2'b10 && cyc < 200) begin
      @(negedge HCLK);
      cyc++;
    end
    while (instruction != 2'b01 && cyc < 200) begin
      @(negedge HCLK);
      cyc++;
    end
    chk("stall_pixel_cycles", cyc, 25);
    n = 0;
    while (instruction != 2'b10 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    busy = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      if (instruction !== 2'b10 || addr_w !== 8'd65 || data_w !== 8'd10) ok = 1'b0;
    end
    busy = 1'b0;
    chk("wr_stall_hold", ok, 1'b1);
    wait_done(cyc);
    chk("stall_done_seen", cyc < 4000, 1'b1);
    chk("stall_writes", {8'(wr_cnt - base_wr), 8'(wr_bad - base_bad)}, {8'd36, 8'd0});
    chk("stall_done_count", done_cnt - base_done, 1);

    // Core backpressure; res_data carries junk while the result is not being collected
    base_wr = wr_cnt; base_done = done_cnt; base_bad = wr_bad;
    go();
    win_ready = 1'b0;
    res_valid = 1'b0;
    n = 0;
    while (!win_valid && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    w = win_data;
    use_force = 1'b1;
    res_force = 8'hEE;
    res_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      if (!win_valid || win_data !== w || instruction !== 2'b00) ok = 1'b0;
    end
    chk("win_hold", ok, 1'b1);
    chk("win_hold_data", w, 72'h12_11_10_0A_09_08_02_01_00);
    win_ready = 1'b1;
    res_valid = 1'b0;
    @(negedge HCLK);
    chk("res_wait_entry", {res_ready, win_valid}, 2'b10);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      if (!res_ready || instruction !== 2'b00) ok = 1'b0;
    end
    chk("res_wait_hold", ok, 1'b1);
    use_force = 1'b0;
    res_valid = 1'b1;
    @(negedge HCLK);
    chk("bp_write_cmd", {instruction, addr_w, data_w}, {2'b10, 8'd64, 8'd9});
    wait_done(cyc);
    chk("bp_writes", {8'(wr_cnt - base_wr), 8'(wr_bad - base_bad)}, {8'd36, 8'd0});

    // Start ignored mid-frame
    base_wr = wr_cnt; base_done = done_cnt; base_bad = wr_bad;
    go();
    repeat (100) @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    wait_done(cyc);
    chk("restart_cycles", cyc + 101, 792);
    chk("restart_writes", {8'(wr_cnt - base_wr), 8'(wr_bad - base_bad)}, {8'd36, 8'd0});
    repeat (30) @(negedge HCLK);
    #2;
    chk("restart_single_done", done_cnt - base_done, 1);
    chk("restart_idle", instruction, 2'b00);

    // Reset during RD_WAIT of pixel 10
    base_wr = wr_cnt; base_done = done_cnt;
    go();
    n = 0;
    while (wr_cnt - base_wr < 10 && n < 1000) begin
      @(negedge HCLK);
      n++;
    end
    while (instruction != 2'b01 && n < 1000) begin
      @(negedge HCLK);
      n++;
    end
    @(negedge HCLK);
    chk("pix10_rd_wait", {instruction, addr_r}, {2'b00, 8'd12});
    HRESET = 1'b0;
    #1;
    chk("abort_outs", {done, win_valid, res_ready, instruction, addr_r, addr_w, data_w},
        {3'b000, 2'b00, 24'd0});
    chk("abort_win", win_data, 72'd0);
    repeat (3) @(negedge HCLK);
    HRESET = 1'b1;
    repeat (5) @(negedge HCLK);
    #2;
    chk("abort_quiet", {8'(done_cnt - base_done), 6'd0, instruction}, 16'd0);
    base_wr = wr_cnt; base_done = done_cnt; base_bad = wr_bad;
    go();
    chk("abort_restart", {instruction, addr_r}, {2'b01, 8'd0});
    wait_done(cyc);
    chk("abort_frame", {8'(wr_cnt - base_wr), 8'(wr_bad - base_bad), 8'(done_cnt - base_done)},
        {8'd36, 8'd0, 8'd1});

    // Minimum 3x3 image with address wrap
    @(negedge HCLK);
    start2 = 1'b1;
    @(negedge HCLK);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    #2;
    chk("min_cycles", n, 22);
    chk("min_reads", rd2_pack, 72'h02_01_00_FF_FE_FD_FC_FB_FA);
    chk("min_read_count", rd2_cnt, 9);
    chk("min_write", {8'(wr2_cnt), wr2_a, wr2_d}, {8'd1, 8'd255, 8'd254});
    chk("min_done", done2_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
